// File: rtl/spi_master_par.sv
// spi_master_par: SPI master with per-transfer mode (CPOL/CPHA), slave select and registered outputs.
// Define SPI_LSB_FIRST_EN to add the Lsb_First input for LSB-first transfers.
module spi_master_par #(
    parameter int DATA_W     = 8,
    parameter int NUM_SLAVES = 4,
    parameter int CLK_DIV    = 2,
    parameter int SS_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            Mode,
    input  logic [SS_W-1:0]       Slave_Select,
    input  logic [DATA_W-1:0]     Tx_Data,
`ifdef SPI_LSB_FIRST_EN
    input  logic                  Lsb_First,
`endif
    input  logic                  MISO,
    output logic                  SCLK,
    output logic                  MOSI,
    output logic [NUM_SLAVES-1:0] SS_N,
    output logic [DATA_W-1:0]     Rx_Data,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int HW = $clog2(2 * DATA_W + 1);
    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hc, h;
    logic [DATA_W-1:0] tx_sr, rx_sr;
    logic cpha, lsb, lsb_in, tick, toggle, sample, shift;
`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = Lsb_First;
`else
    assign lsb_in = 1'b0;
`endif
    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic l);
        return l ? v[0] : v[DATA_W-1];
    endfunction
    function automatic logic [DATA_W-1:0] drop(input logic [DATA_W-1:0] v, input logic l);
        return l ? v >> 1 : v << 1;
    endfunction
    // h indexes the SCLK edge produced this cycle: even = leading, odd = trailing
    always_comb begin
        tick   = cnt == CW'(CLK_DIV - 1);
        h      = state == LEAD ? '0 : hc;
        toggle = tick && (state == LEAD || (state == SHIFT && hc != HW'(2 * DATA_W)));
        sample = toggle && (h[0] == cpha);
        shift  = toggle && (cpha ? !h[0] : (h[0] && h != HW'(2 * DATA_W - 1)));
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hc      <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            cpha    <= 1'b0;
            lsb     <= 1'b0;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
            SS_N    <= '1;
            Rx_Data <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Error   <= 1'b0;
        end else begin
            Done  <= 1'b0;
            Error <= 1'b0;
            if (sample)
                rx_sr <= lsb ? {MISO, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], MISO};
            if (shift) begin
                MOSI  <= first_bit(tx_sr, lsb);
                tx_sr <= drop(tx_sr, lsb);
            end
            case (state)
                IDLE: begin
                    if (Start && int'(Slave_Select) < NUM_SLAVES) begin
                        state <= LEAD;
                        cnt   <= '0;
                        hc    <= '0;
                        Busy  <= 1'b1;
                        SS_N  <= ~(NUM_SLAVES'(1) << Slave_Select);
                        SCLK  <= Mode[1];
                        cpha  <= Mode[0];
                        lsb   <= lsb_in;
                        // CPHA=0 presents the first bit immediately; CPHA=1 waits for the first leading edge
                        MOSI  <= Mode[0] ? 1'b0 : first_bit(Tx_Data, lsb_in);
                        tx_sr <= Mode[0] ? Tx_Data : drop(Tx_Data, lsb_in);
                    end else if (Start) begin
                        Error <= 1'b1;
                    end
                end
                LEAD, SHIFT: begin
                    cnt <= tick ? '0 : cnt + CW'(1);
                    if (toggle) begin
                        SCLK  <= ~SCLK;
                        hc    <= h + HW'(1);
                        state <= SHIFT;
                    end else if (tick) begin
                        state <= TRAIL;
                    end
                end
                TRAIL: begin
                    cnt <= tick ? '0 : cnt + CW'(1);
                    if (tick) begin
                        state   <= IDLE;
                        SS_N    <= '1;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Rx_Data <= rx_sr;
                        MOSI    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_par.sv
// tb_spi_master_par: directed bench for spi_master_par with a cycle-offset reference model.
module tb_spi_master_par;
    localparam int W = 8, NS = 4, D = 2, SW = 3, LAT = D * (2 * W + 2);
    logic Clock = 1'b0, Reset = 1'b1, Start = 1'b0, MISO;
    logic [1:0] Mode = '0;
    logic [SW-1:0] Slave_Select = '0;
    logic [W-1:0] Tx_Data = '0;
    logic SCLK, MOSI, Busy, Done, Error;
    logic [NS-1:0] SS_N;
    logic [W-1:0] Rx_Data;
    logic t_lsb;
`ifdef SPI_LSB_FIRST_EN
    logic Lsb_First = 1'b0;
    assign t_lsb = Lsb_First;
`else
    assign t_lsb = 1'b0;
`endif
    always #5 Clock = ~Clock;

    spi_master_par #(.DATA_W(W), .NUM_SLAVES(NS), .CLK_DIV(D), .SS_W(SW)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode),
        .Slave_Select(Slave_Select), .Tx_Data(Tx_Data),
`ifdef SPI_LSB_FIRST_EN
        .Lsb_First(Lsb_First),
`endif
        .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI), .SS_N(SS_N), .Rx_Data(Rx_Data),
        .Busy(Busy), .Done(Done), .Error(Error));

    int checks = 0, errs = 0, cyc_n = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Slave: loopback or a real MSB-first slave shifting s_word in mode s_mode
    logic loop = 1'b1, s_miso = 1'b0, s_lead = 1'b0;
    logic [1:0] s_mode = '0;
    logic [W-1:0] s_word = '0;
    int s_i = 0;
    assign MISO = loop ? MOSI : s_miso;
    always @(SS_N) begin
        s_i = 0;
        s_lead = 1'b0;
        if (!(&SS_N) && !s_mode[0]) begin
            s_miso = s_word[W-1];
            s_i = 1;
        end
    end
    always @(SCLK) begin
        if (!(&SS_N)) begin
            if (SCLK != s_mode[1]) begin
                s_lead = 1'b1;
                if (s_mode[0] && s_i < W) begin
                    s_miso = s_word[W-1-s_i];
                    s_i++;
                end
            end else if (s_lead && !s_mode[0] && s_i < W) begin
                s_miso = s_word[W-1-s_i];
                s_i++;
            end
        end
    end

    // Reference model: cycle offset k since the accept edge determines every output
    int m_k = 0;
    logic m_valid = 1'b0, m_act = 1'b0, m_done = 1'b0, m_err = 1'b0, m_cpol = 1'b0, m_lsb = 1'b0;
    logic [1:0] m_mode = '0;
    logic [SW-1:0] m_sel = '0;
    logic [W-1:0] m_tx = '0, m_rxw = '0, m_rx = '0;
    always @(posedge Clock) begin
        cyc_n++;
        m_done = 1'b0;
        m_err = 1'b0;
        if (Reset) begin
            m_valid = 1'b1;
            m_act = 1'b0;
            m_cpol = 1'b0;
            m_rx = '0;
        end else if (m_act) begin
            m_k++;
            if (m_k == LAT) begin
                m_act = 1'b0;
                m_done = 1'b1;
                m_rx = m_rxw;
            end
        end else if (Start) begin
            if (Slave_Select < NS) begin
                m_act = 1'b1;
                m_k = 0;
                m_mode = Mode;
                m_cpol = Mode[1];
                m_sel = Slave_Select;
                m_tx = Tx_Data;
                m_lsb = t_lsb;
                m_rxw = loop ? Tx_Data : s_word;
            end else begin
                m_err = 1'b1;
            end
        end
    end
    function automatic logic e_sclk(input int k);
        if (k < D || k >= D * (2 * W + 1)) return m_cpol;
        return m_cpol ^ (((k - D) / D) % 2 == 0);
    endfunction
    function automatic logic e_mosi(input int k);
        int j, b;
        j = (k < D) ? -1 : ((k - D) / D > 2 * W - 1 ? 2 * W - 1 : (k - D) / D);
        if (m_mode[0] && j < 0) return 1'b0;
        b = m_mode[0] ? j / 2 : ((j + 1) / 2 > W - 1 ? W - 1 : (j + 1) / 2);
        return m_lsb ? m_tx[b] : m_tx[W-1-b];
    endfunction

    // Observation counters and the per-cycle compare against the model
    int rise_cnt = 0, ones_cnt = 0, done_cnt = 0, acc_obs = 0, done_obs = 0;
    logic [W-1:0] mosi_cap = '0;
    logic p_sclk = 1'b0, p_busy = 1'b0;
    always @(negedge Clock) begin
        if (SCLK === 1'b1 && p_sclk === 1'b0 && p_busy === 1'b1) begin
            rise_cnt++;
            mosi_cap = {mosi_cap[W-2:0], MOSI};
        end
        if (MOSI === 1'b1) ones_cnt++;
        if (Done === 1'b1) begin
            done_cnt++;
            done_obs = cyc_n;
        end
        if (Busy === 1'b1 && p_busy !== 1'b1) acc_obs = cyc_n;
        p_sclk = SCLK;
        p_busy = Busy;
        if (m_valid) begin
            chk("busy", Busy, m_act);
            chk("ss_n", SS_N, m_act ? NS'(~(NS'(1) << m_sel)) : {NS{1'b1}});
            chk("sclk", SCLK, m_act ? e_sclk(m_k) : m_cpol);
            chk("mosi", MOSI, m_act ? e_mosi(m_k) : 1'b0);
            chk("done", Done, m_done);
            chk("error", Error, m_err);
            chk("rx_data", Rx_Data, m_rx);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clock);
            #2;
        end
    endtask
    task automatic start(input logic [1:0] m, input logic [SW-1:0] s, input logic [W-1:0] d);
        Mode = m;
        Slave_Select = s;
        Tx_Data = d;
        Start = 1'b1;
        cyc(1);
        Start = 1'b0;
    endtask
    task automatic wait_done(input string nm);
        int n0, t;
        n0 = done_cnt;
        t = 0;
        while (done_cnt == n0 && t < 4 * LAT) begin
            cyc(1);
            t++;
        end
        chk(nm, done_cnt - n0, 1);
    endtask

    initial begin
        int d0;
        Start = 1'b1;
        cyc(2);
        Reset = 1'b0;
        Start = 1'b0;
        chk("rst_ss_n", SS_N, 4'hF);
        chk("rst_busy", Busy, 0);
        chk("rst_rx", Rx_Data, 0);
        chk("rst_sclk", SCLK, 0);
        chk("rst_mosi", MOSI, 0);
        // mode 0 loopback
        rise_cnt = 0;
        start(2'd0, 3'd1, 8'hA5);
        chk("m0_ss_n", SS_N, 4'b1101);
        wait_done("m0_done");
        chk("m0_latency", done_obs - acc_obs, 36);
        chk("m0_rises", rise_cnt, 8);
        chk("m0_rx", Rx_Data, 8'hA5);
        // mode 3 with a real slave sending 0xC3
        rise_cnt = 0;
        mosi_cap = '0;
        loop = 1'b0;
        s_mode = 2'd3;
        s_word = 8'hC3;
        start(2'd3, 3'd2, 8'h3C);
        chk("m3_ss_n", SS_N, 4'b1011);
        wait_done("m3_done");
        chk("m3_rx", Rx_Data, 8'hC3);
        chk("m3_mosi_seq", mosi_cap, 8'h3C);
        chk("m3_rises", rise_cnt, 8);
        cyc(1);
        chk("m3_idle_sclk", SCLK, 1);
        loop = 1'b1;
        // out-of-range slave
        start(2'd0, 3'd5, 8'h00);
        chk("err_pulse", Error, 1);
        chk("err_busy", Busy, 0);
        chk("err_ss_n", SS_N, 4'hF);
        cyc(1);
        chk("err_clear", Error, 0);
        // Start and input changes mid-transfer are ignored
        ones_cnt = 0;
        d0 = done_cnt;
        start(2'd0, 3'd0, 8'h00);
        cyc(9);
        Mode = 2'd3;
        Slave_Select = 3'd3;
        Tx_Data = 8'hFF;
        Start = 1'b1;
        cyc(1);
        Start = 1'b0;
        wait_done("ign_done");
        cyc(5);
        chk("ign_mosi_ones", ones_cnt, 0);
        chk("ign_done_count", done_cnt - d0, 1);
        chk("ign_rx", Rx_Data, 0);
        // Start held high: accepted again on the cycle after Done
        Mode = 2'd1;
        Slave_Select = 3'd3;
        Tx_Data = 8'h5A;
        Start = 1'b1;
        cyc(1);
        Tx_Data = 8'h96;
        wait_done("b2b_first");
        Start = 1'b0;
        chk("b2b_rx1", Rx_Data, 8'h5A);
        cyc(1);
        chk("b2b_reaccept", acc_obs - done_obs, 1);
        wait_done("b2b_second");
        chk("b2b_rx2", Rx_Data, 8'h96);
        // reset mid-transfer
        start(2'd2, 3'd1, 8'hF0);
        cyc(14);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        chk("mrst_ss_n", SS_N, 4'hF);
        chk("mrst_busy", Busy, 0);
        chk("mrst_rx", Rx_Data, 0);
        chk("mrst_sclk", SCLK, 0);
        d0 = done_cnt;
        cyc(LAT + 10);
        chk("mrst_no_done", done_cnt - d0, 0);
`ifdef SPI_LSB_FIRST_EN
        Lsb_First = 1'b1;
        start(2'd1, 3'd0, 8'h01);
        Lsb_First = 1'b0;
        cyc(D);
        chk("lsb_first_bit", MOSI, 1);
        wait_done("lsb_done");
        chk("lsb_rx", Rx_Data, 8'h01);
`endif
        cyc(3);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_master_par.md
SPI_MASTER_PAR -- requirements
Module: spi_master_par

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per transfer (>=2).
REQ-002 SHALL have parameter NUM_SLAVES, default 4, number of chip-selects (>=1); SS_W = max(1, clog2(NUM_SLAVES)).
REQ-003 SHALL have parameter CLK_DIV, default 2, SCLK half-period in Clock cycles (>=1).
REQ-004 SHALL use one clock; reset is synchronous and active-high, ports Clock and Reset.
REQ-005 SHALL have ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous active-high reset
Start  in  1  request transfer, sampled in IDLE only
Mode  in  2  [1]=CPOL, [0]=CPHA, latched at accept
Slave_Select  in  SS_W  target slave index, latched at accept
Tx_Data  in  DATA_W  word to send, latched at accept
MISO  in  1  serial data from slave
SCLK  out  1  serial clock
MOSI  out  1  serial data to slave
SS_N  out  NUM_SLAVES  one-hot-low chip selects
Rx_Data  out  DATA_W  last received word
Busy  out  1  transfer in progress
Done  out  1  one-cycle pulse, transfer complete
Error  out  1  one-cycle pulse, Start rejected

Function
REQ-006 SHALL implement FSM IDLE -> LEAD -> SHIFT -> TRAIL -> IDLE; all outputs registered.
REQ-007 Start=1 in IDLE with Slave_Select<NUM_SLAVES SHALL accept: latch Mode/Slave_Select/Tx_Data, Busy=1, selected SS_N bit=0, SCLK=CPOL, enter LEAD, all at the accepting edge.
REQ-008 Start=1 in IDLE with Slave_Select>=NUM_SLAVES SHALL pulse Error for one cycle, remain IDLE, SS_N all ones.
REQ-009 Start while Busy=1 SHALL be ignored; Mode/Slave_Select/Tx_Data changes mid-transfer SHALL have no effect.
REQ-010 LEAD SHALL last CLK_DIV cycles; SHIFT SHALL last 2*DATA_W half-periods of CLK_DIV cycles, SCLK toggling at each half-period boundary (DATA_W full SCLK pulses); TRAIL SHALL last CLK_DIV cycles with SCLK=CPOL.
REQ-011 CPHA=0: first MOSI bit valid from accept edge; MISO sampled on each leading SCLK edge; MOSI shifts on each trailing edge except the last.
REQ-012 CPHA=1: MOSI shifts on each leading edge (first bit driven at first leading edge); MISO sampled on each trailing edge.
REQ-013 Default bit order SHALL be MSB-first for both MOSI and MISO.
REQ-014 At end of TRAIL SHALL, on one edge: deassert SS_N to all ones, Busy=0, Done=1 for one cycle, Rx_Data = received word; accept-to-Done latency exactly CLK_DIV*(2*DATA_W+2) cycles.
REQ-015 Rx_Data SHALL hold its value between Done pulses; Start accepted the cycle after Done.
REQ-016 In IDLE SCLK SHALL hold CPOL of the last accepted Mode (0 after reset); MOSI SHALL hold 0.
REQ-017 Half-period counter SHALL be clog2(CLK_DIV+1) bits, bit counter clog2(2*DATA_W+1) bits, no wrap inside a transfer.

Reset
REQ-018 Reset=1 SHALL, at the next edge, in any state including mid-transfer: FSM=IDLE, SCLK=0, MOSI=0, SS_N=all ones, Rx_Data=0, Busy=0, Done=0, Error=0; partial receive discarded, no Done.
REQ-019 Reset SHALL dominate Start on the same edge.

Configuration
REQ-020 Macro SPI_LSB_FIRST_EN defined SHALL add input Lsb_First (1 bit, latched at accept); Lsb_First=1 sends/receives LSB-first, 0 MSB-first.
REQ-021 Without SPI_LSB_FIRST_EN port Lsb_First SHALL not exist and order SHALL be MSB-first only.

Verification
REQ-022 Mode 0, DATA_W=8, CLK_DIV=2, Slave_Select=1, Tx_Data=0xA5, MISO tied to MOSI -> SS_N=4'b1101, 8 rising SCLK edges, Done 36 cycles after accept, Rx_Data=0xA5.
REQ-023 Mode 3, Tx_Data=0x3C, MISO driven 0xC3 MSB-first on falling edges -> SCLK idles 1, Rx_Data=0xC3, MOSI sequence 0,0,1,1,1,1,0,0.
REQ-024 Slave_Select=5 with NUM_SLAVES=4, SS_W=3, Start=1 -> Error pulse 1 cycle, Busy stays 0, SS_N=4'b1111.
REQ-025 Start re-asserted with Tx_Data=0xFF at cycle 10 of a 0x00 transfer -> ignored, MOSI all 0, one Done only.
REQ-026 Reset asserted 15 cycles into transfer -> next edge SS_N=all ones, Busy=0, Rx_Data=0, no Done.
REQ-027 SPI_LSB_FIRST_EN, Lsb_First=1, Mode 1, Tx_Data=0x01, loopback -> first MOSI bit 1, Rx_Data=0x01.
